// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// Module      : ram_ctrl_pkg (package)
// Description : Shared types and default widths for the RAM access controller.
//               Provides the controller state encoding and the default
//               address/data widths of the 8x8 RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_DATA_W = 8;

  // VFY_* states are only reachable when RAM_WRITE_VERIFY_EN is defined.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR         = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    RSP        = 3'd4,
    VFY_ISSUE  = 3'd5,
    VFY_CHECK  = 3'd6
  } state_e;

endpackage : ram_ctrl_pkg

`default_nettype wire

// File: rtl/ram_8bit.sv
// ============================================================================
// Module      : ram_8bit
// Description : Single-port RAM with registered read data (1-cycle latency).
//               Contents clear on synchronous reset.
// Ports       : clk, rst      - clock / synchronous active-high reset
//               address       - read/write address
//               data_in, we   - write data and write enable
//               data_out      - registered read data (old data on a write)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_8bit #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out <= '0;
    end else begin
      if (we) begin
        mem_q[address] <= data_in;
      end
      data_out <= mem_q[address];
    end
  end

endmodule : ram_8bit

`default_nettype wire

// File: rtl/ram_access_ctrl.sv
// ============================================================================
// Module      : ram_access_ctrl
// Description : Valid/ready request front-end for a single-port RAM with a
//               registered read port. Turns accepted requests into RAM
//               address/data_in/we cycles, absorbs the read latency and
//               returns read data on a backpressurable response channel.
//               One request in flight at a time.
// Ports       : clk, rst                 - clock / sync active-high reset
//               req_valid/ready          - request handshake
//               req_write/addr/wdata     - request payload
//               rsp_valid/ready, rsp_rdata - read response channel
//               ram_address/data_in/we   - RAM control outputs
//               ram_data_out             - RAM registered read data
//               busy                     - controller not in IDLE
//               verify_err               - sticky write-verify error
//                                          (only with RAM_WRITE_VERIFY_EN)
// Config      : RAM_WRITE_VERIFY_EN - read back every write and flag
//               mismatches on verify_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_out,
`ifdef RAM_WRITE_VERIFY_EN
  output logic              verify_err,
`endif
  output logic              busy
);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ram_we_q,    ram_we_d;
`ifdef RAM_WRITE_VERIFY_EN
  logic              verify_err_q, verify_err_d;
`endif

  logic w_accept;

  // Gated by rst so no request can be taken while reset is held.
  assign req_ready = (state_q == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = rsp_valid_q;
    ram_we_d    = 1'b0;
`ifdef RAM_WRITE_VERIFY_EN
    verify_err_d = verify_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_write) begin
            state_d  = WR;
            // ram_we is registered, so it is raised on entry to WR.
            ram_we_d = 1'b1;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      WR: begin
`ifdef RAM_WRITE_VERIFY_EN
        state_d = VFY_ISSUE;
`else
        state_d = IDLE;
`endif
      end
      // RAM samples addr_q on the edge leaving RD_ISSUE; its data_out is
      // valid throughout RD_CAPTURE.
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        rsp_rdata_d = ram_data_out;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef RAM_WRITE_VERIFY_EN
      VFY_ISSUE: state_d = VFY_CHECK;
      VFY_CHECK: begin
        if (ram_data_out != wdata_q) begin
          verify_err_d = 1'b1;
        end
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      ram_we_q    <= 1'b0;
`ifdef RAM_WRITE_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ram_we_q    <= ram_we_d;
`ifdef RAM_WRITE_VERIFY_EN
      verify_err_q <= verify_err_d;
`endif
    end
  end

  // Address and write data are held in addr_q/wdata_q in every state.
  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;
  assign ram_we      = ram_we_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = (state_q != IDLE);
`ifdef RAM_WRITE_VERIFY_EN
  assign verify_err  = verify_err_q;
`endif

endmodule : ram_access_ctrl

`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
// ============================================================================
// Module      : tb_ram_access_ctrl
// Description : Self-checking bench for ram_access_ctrl driving ram_8bit.
//               Read expectations come from a bench-side memory model and
//               are queued at request acceptance, then compared when the
//               response handshake is seen.
// Config      : RAM_WRITE_VERIFY_EN enables the write-verify section.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_access_ctrl;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
`ifdef RAM_WRITE_VERIFY_EN
  localparam int WR_CYC = 4;
`else
  localparam int WR_CYC = 2;
`endif
  localparam int RD_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] ctrl_rdata;
  logic              busy;
  logic              corrupt = 1'b0;
`ifdef RAM_WRITE_VERIFY_EN
  logic              verify_err;
`endif

  always #5 clk = ~clk;

  // Lets the bench present wrong read-back data to the controller.
  assign ctrl_rdata = corrupt ? ~ram_dout : ram_dout;

  ram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ctrl_rdata),
`ifdef RAM_WRITE_VERIFY_EN
    .verify_err   (verify_err),
`endif
    .busy         (busy)
  );

  ram_8bit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk      (clk),
    .rst      (rst),
    .address  (ram_address),
    .data_in  (ram_data_in),
    .we       (ram_we),
    .data_out (ram_dout)
  );

  int              n_assert = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  int              we_cycles = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] model [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard and write-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we === 1'b1) we_cycles++;
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // Present one request and hold it until accepted; acc = accept cycle.
  task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input bit track, output int acc);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cyc;
    check("req_accept", 32'(done), 32'd1);
    if (done && track) begin
      if (wr) model[a] = d;
      else    exp_q.push_back(model[a]);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int lat;
    int we0;
    int wacc [8];
    int racc [8];
    int seen;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset state while rst is still high.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_ram_we",    32'(ram_we),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_ram_addr",  32'(ram_address), 32'd0);
`ifdef RAM_WRITE_VERIFY_EN
    check("rst_verify_err", 32'(verify_err), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Read @5 with no prior write; count edges until rsp_valid. The
    // accepting edge is the first of three, so two further edges follow.
    send(1'b0, 3'd5, 8'h00, 1'b1, acc);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) break;
      @(posedge clk);
      lat++;
    end
    check("rd_latency_edges", 32'(lat), 32'd2);
    wait_idle();

    // Write 0xA5 @3: single write-enable cycle carrying the request.
    we0 = we_cycles;
    send(1'b1, 3'd3, 8'hA5, 1'b1, acc);
    @(negedge clk);
    check("wr_ram_we",   32'(ram_we),      32'd1);
    check("wr_ram_addr", 32'(ram_address), 32'd3);
    check("wr_ram_din",  32'(ram_data_in), 32'hA5);
    wait_idle();
    check("wr_we_pulses", 32'(we_cycles - we0), 32'd1);
    send(1'b0, 3'd3, 8'h00, 1'b1, acc);
    wait_idle();

    // Backpressured read @1: response held stable, no new acceptance.
    send(1'b1, 3'd1, 8'h5C, 1'b1, acc);
    wait_idle();
    rsp_ready = 1'b0;
    send(1'b0, 3'd1, 8'h00, 1'b1, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) break;
    end
    for (int k = 0; k < 4; k++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", 32'(rsp_rdata), 32'h5C);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      if (k == 3) rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_done_valid", 32'(rsp_valid), 32'd0);
    wait_idle();

    // Back-to-back writes 0x11..0x88 @0..7, then reads @7..0.
    we0 = we_cycles;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 3'(i), 8'((i + 1) * 8'h11), 1'b1, wacc[i]);
    end
    wait_idle();
    check("wr_burst_we_pulses", 32'(we_cycles - we0), 32'd8);
    check("wr_throughput", 32'(wacc[1] - wacc[0]), 32'(WR_CYC));
    for (int i = 7; i >= 0; i--) begin
      send(1'b0, 3'(i), 8'h00, 1'b1, racc[i]);
    end
    wait_idle();
    check("rd_throughput", 32'(racc[5] - racc[6]), 32'(RD_CYC));

    // Reset while the read sits in RD_CAPTURE: the read is dropped.
    send(1'b0, 3'd2, 8'h00, 1'b0, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    @(negedge clk);
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_busy_low",  32'(busy),      32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    check("rstmid_no_rsp", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    send(1'b0, 3'd7, 8'h00, 1'b1, acc);
    wait_idle();

`ifdef RAM_WRITE_VERIFY_EN
    send(1'b1, 3'd6, 8'h66, 1'b1, acc);
    wait_idle();
    check("vfy_clean", 32'(verify_err), 32'd0);
    corrupt = 1'b1;
    send(1'b1, 3'd4, 8'h3C, 1'b1, acc);
    wait_idle();
    corrupt = 1'b0;
    check("vfy_err_set", 32'(verify_err), 32'd1);
    send(1'b1, 3'd4, 8'h3D, 1'b1, acc);
    wait_idle();
    check("vfy_err_sticky", 32'(verify_err), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("vfy_err_cleared", 32'(verify_err), 32'd0);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_ram_access_ctrl

`default_nettype wire
